// File: rtl/rsa_sched_pkg.sv
// Shared definitions for the RSA job scheduler: FSM state encoding, default wait timeout
// and the two-way round-robin pick function.
package rsa_sched_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StInvRst  = 3'd1;
    localparam logic [2:0] StInvWait = 3'd2;
    localparam logic [2:0] StExpRst  = 3'd3;
    localparam logic [2:0] StExpWait = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    localparam int unsigned DefaultTimeout = 65535;

    // With both requesters valid, favour the one that was not granted last.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_was_1);
        logic [1:0] pick;
        if (valid == 2'b11) begin
            pick = last_was_1 ? 2'b01 : 2'b10;
        end else begin
            pick = valid;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rsa_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant and a last-grant register that
// favours requester 0 out of reset.
module rsa_rr_arb2
    import rsa_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       grant_en_i,
    output logic [1:0] grant_o
);

    logic last_q;

    assign grant_o = grant_en_i ? rr_pick({valid1_i, valid0_i}, last_q) : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (grant_o != 2'b00) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Arbitrates RSA jobs from two requesters onto one control engine and sequences the
// inverter and mod-exp phases, aborting a phase that exceeds TIMEOUT wait cycles.
module rsa_job_scheduler
    import rsa_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_p,
    input  logic [WIDTH-1:0]   req0_q,
    input  logic               req0_encrypt_decrypt,
    input  logic [2*WIDTH-1:0] req0_msg,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_p,
    input  logic [WIDTH-1:0]   req1_q,
    input  logic               req1_encrypt_decrypt,
    input  logic [2*WIDTH-1:0] req1_msg,

    output logic [WIDTH-1:0]   eng_p,
    output logic [WIDTH-1:0]   eng_q,
    output logic               eng_encrypt_decrypt,
    output logic [2*WIDTH-1:0] eng_msg,
    output logic               eng_reset_inverter,
    output logic               eng_reset_mod_exp,
    input  logic               eng_inverter_finish,
    input  logic               eng_mod_exp_finish,
    input  logic [2*WIDTH-1:0] eng_msg_out,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_msg,
    output logic               rsp_timeout,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         grant;
    logic               grant_en;
    logic               timeout_hit;

    logic               job_id_q;
    logic [WIDTH-1:0]   job_p_q;
    logic [WIDTH-1:0]   job_q_q;
    logic               job_ed_q;
    logic [2*WIDTH-1:0] job_msg_q;

    logic [2*WIDTH-1:0] rsp_msg_q, rsp_msg_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    assign grant_en = reset_n && (state_q == StIdle);

    rsa_rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid0_i   (req0_valid),
        .valid1_i   (req1_valid),
        .grant_en_i (grant_en),
        .grant_o    (grant)
    );

    // cnt_q counts completed wait cycles, so the wait phase lasts at most TIMEOUT cycles.
    assign timeout_hit = (32'(cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_msg_d     = rsp_msg_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    state_d = StInvRst;
                end
            end
            StInvRst: begin
                cnt_d   = '0;
                state_d = StInvWait;
            end
            StInvWait: begin
                if (eng_inverter_finish) begin
                    state_d = StExpRst;
                end else if (timeout_hit) begin
                    state_d       = StDone;
                    rsp_msg_d     = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StExpRst: begin
                cnt_d   = '0;
                state_d = StExpWait;
            end
            StExpWait: begin
                if (eng_mod_exp_finish) begin
                    state_d       = StDone;
                    rsp_msg_d     = eng_msg_out;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = StDone;
                    rsp_msg_d     = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            job_id_q      <= 1'b0;
            job_p_q       <= '0;
            job_q_q       <= '0;
            job_ed_q      <= 1'b0;
            job_msg_q     <= '0;
            rsp_msg_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rsp_msg_q     <= rsp_msg_d;
            rsp_timeout_q <= rsp_timeout_d;
            if (grant != 2'b00) begin
                job_id_q  <= grant[1];
                job_p_q   <= grant[1] ? req1_p : req0_p;
                job_q_q   <= grant[1] ? req1_q : req0_q;
                job_ed_q  <= grant[1] ? req1_encrypt_decrypt : req0_encrypt_decrypt;
                job_msg_q <= grant[1] ? req1_msg : req0_msg;
            end
        end
    end

    // Outputs are forced low while reset_n is held, not just after the next edge.
    assign req0_ready          = grant[0];
    assign req1_ready          = grant[1];
    assign eng_p               = reset_n ? job_p_q : '0;
    assign eng_q               = reset_n ? job_q_q : '0;
    assign eng_encrypt_decrypt = reset_n && job_ed_q;
    assign eng_msg             = reset_n ? job_msg_q : '0;
    assign eng_reset_inverter  = reset_n && (state_q == StInvRst);
    assign eng_reset_mod_exp   = reset_n && (state_q == StExpRst);
    assign rsp_valid           = reset_n && (state_q == StDone);
    assign rsp_id              = reset_n && job_id_q;
    assign rsp_msg             = reset_n ? rsp_msg_q : '0;
    assign rsp_timeout         = reset_n && rsp_timeout_q;
    assign busy                = reset_n && (state_q != StIdle);

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Randomized self-checking bench for rsa_job_scheduler against a cycle-count job model
// and a behavioural engine whose finish levels follow each phase pulse by a set delay.
module tb_rsa_job_scheduler;

    localparam int unsigned W = 128;
    localparam int unsigned T = 16;
    localparam int unsigned OutW = 2 + W + W + 1 + 2 * W + 2 + 1 + 1 + 2 * W + 1 + 1;

    typedef struct {
        logic [W-1:0]   p;
        logic [W-1:0]   q;
        logic           ed;
        logic [2*W-1:0] msg;
    } job_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [W-1:0] req0_p = '0, req0_q = '0, req1_p = '0, req1_q = '0;
    logic req0_ed = 1'b0, req1_ed = 1'b0;
    logic [2*W-1:0] req0_msg = '0, req1_msg = '0;
    logic [W-1:0] eng_p, eng_q;
    logic eng_ed;
    logic [2*W-1:0] eng_msg, eng_msg_out;
    logic eng_reset_inverter, eng_reset_mod_exp;
    logic inv_fin = 1'b0, exp_fin = 1'b0;
    logic rsp_valid, rsp_id, rsp_timeout, busy;
    logic rsp_ready = 1'b0;
    logic [2*W-1:0] rsp_msg;
    logic [OutW-1:0] all_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int inv_delay = 1, exp_delay = 1;
    int inv_cnt = 0, exp_cnt = 0;
    int inv_pulses = 0, exp_pulses = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsa_job_scheduler #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req0_valid           (req0_valid),
        .req0_ready           (req0_ready),
        .req0_p               (req0_p),
        .req0_q               (req0_q),
        .req0_encrypt_decrypt (req0_ed),
        .req0_msg             (req0_msg),
        .req1_valid           (req1_valid),
        .req1_ready           (req1_ready),
        .req1_p               (req1_p),
        .req1_q               (req1_q),
        .req1_encrypt_decrypt (req1_ed),
        .req1_msg             (req1_msg),
        .eng_p                (eng_p),
        .eng_q                (eng_q),
        .eng_encrypt_decrypt  (eng_ed),
        .eng_msg              (eng_msg),
        .eng_reset_inverter   (eng_reset_inverter),
        .eng_reset_mod_exp    (eng_reset_mod_exp),
        .eng_inverter_finish  (inv_fin),
        .eng_mod_exp_finish   (exp_fin),
        .eng_msg_out          (eng_msg_out),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_id               (rsp_id),
        .rsp_msg              (rsp_msg),
        .rsp_timeout          (rsp_timeout),
        .busy                 (busy)
    );

    assign all_out = {req0_ready, req1_ready, eng_p, eng_q, eng_ed, eng_msg, eng_reset_inverter,
                      eng_reset_mod_exp, rsp_valid, rsp_id, rsp_msg, rsp_timeout, busy};

    // Stand-in engine arithmetic; any mix of all operands serves to expose misrouting.
    function automatic logic [2*W-1:0] engine_fn(input logic [W-1:0] p, input logic [W-1:0] q,
                                                 input logic ed, input logic [2*W-1:0] m);
        return ed ? (m ^ {p, q}) : (m + {q, p});
    endfunction

    assign eng_msg_out = engine_fn(eng_p, eng_q, eng_ed, eng_msg);

    // Delay d: finish rises d cycles after the pulse cycle; d = 0 never finishes.
    always @(posedge clk) begin
        if (eng_reset_inverter) begin
            inv_pulses <= inv_pulses + 1;
            inv_fin    <= (inv_delay == 1);
            inv_cnt    <= (inv_delay > 1) ? inv_delay - 1 : 0;
        end else if (inv_cnt != 0) begin
            inv_cnt <= inv_cnt - 1;
            if (inv_cnt == 1) inv_fin <= 1'b1;
        end
        if (eng_reset_mod_exp) begin
            exp_pulses <= exp_pulses + 1;
            exp_fin    <= (exp_delay == 1);
            exp_cnt    <= (exp_delay > 1) ? exp_delay - 1 : 0;
        end else if (exp_cnt != 0) begin
            exp_cnt <= exp_cnt - 1;
            if (exp_cnt == 1) exp_fin <= 1'b1;
        end
    end

    // Job-level reference: outcome, payload, grant-to-response latency and pulse counts.
    function automatic void model(input job_t j, input int di, input int de, output bit to,
                                  output logic [2*W-1:0] m, output int lat, output int ni,
                                  output int ne);
        ni = 1;
        if (di == 0 || di > int'(T)) begin
            to = 1'b1; m = '0; lat = 2 + int'(T); ne = 0;
        end else if (de == 0 || de > int'(T)) begin
            to = 1'b1; m = '0; lat = 3 + di + int'(T); ne = 1;
        end else begin
            to = 1'b0; m = engine_fn(j.p, j.q, j.ed, j.msg); lat = 3 + di + de; ne = 1;
        end
    endfunction

    function automatic job_t rand_job();
        job_t j;
        for (int i = 0; i < int'(W / 32); i++) begin
            j.p[i*32 +: 32] = $urandom;
            j.q[i*32 +: 32] = $urandom;
        end
        for (int i = 0; i < int'(2 * W / 32); i++) j.msg[i*32 +: 32] = $urandom;
        j.ed = 1'($urandom_range(0, 1));
        return j;
    endfunction

    function automatic logic rdy(input int k);
        return (k == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic drive_req(input int k, input job_t j, input logic v);
        if (k == 0) begin
            req0_p = j.p; req0_q = j.q; req0_ed = j.ed; req0_msg = j.msg; req0_valid = v;
        end else begin
            req1_p = j.p; req1_q = j.q; req1_ed = j.ed; req1_msg = j.msg; req1_valid = v;
        end
    endtask

    // Stimulus only: presents a job, measures latency and captures the response.
    task automatic do_job(input int k, input job_t j, output bit got, output int lat,
                          output logic rid, output logic rto, output logic [2*W-1:0] rmsg);
        int n;
        int g;
        got = 1'b0; lat = 0; rid = 1'b0; rto = 1'b0; rmsg = '0;
        @(negedge clk);
        drive_req(k, j, 1'b1);
        #1;
        n = 0;
        while (rdy(k) !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (rdy(k) !== 1'b1) begin
            drive_req(k, j, 1'b0);
            return;
        end
        g = cyc;
        @(negedge clk);
        drive_req(k, j, 1'b0);
        #1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) return;
        got = 1'b1; lat = cyc - g; rid = rsp_id; rto = rsp_timeout; rmsg = rsp_msg;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ((|all_out) !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_single_job();
        job_t j;
        bit got; int lat; logic rid, rto; logic [2*W-1:0] rmsg;
        int i0, e0;
        j.p = 128'd113680897410347;
        j.q = 128'd7999808077935876437321;
        j.ed = 1'b0;
        j.msg = 256'h806a3e00000000000000000000;
        inv_delay = 3; exp_delay = 3;
        i0 = inv_pulses; e0 = exp_pulses;
        do_job(0, j, got, lat, rid, rto, rmsg);
        checks++;
        if (!got) begin errors++; $display("FAIL single_got got=0 want=1"); end
        checks++;
        if (lat != 9) begin errors++; $display("FAIL single_latency got=%0d want=9", lat); end
        checks++;
        if (rid !== 1'b0 || rto !== 1'b0) begin
            errors++; $display("FAIL single_id_to got=%b%b want=00", rid, rto);
        end
        checks++;
        if (rmsg !== engine_fn(j.p, j.q, j.ed, j.msg)) begin
            errors++;
            $display("FAIL single_msg got=%h want=%h", rmsg, engine_fn(j.p, j.q, j.ed, j.msg));
        end
        checks++;
        if (inv_pulses - i0 != 1 || exp_pulses - e0 != 1) begin
            errors++;
            $display("FAIL single_pulses got=%0d/%0d want=1/1", inv_pulses - i0, exp_pulses - e0);
        end
    endtask

    task automatic test_back_to_back();
        job_t j0, j1;
        bit exp_id;
        int ngr, n;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        inv_delay = 1; exp_delay = 1; rsp_ready = 1'b1;
        j0 = rand_job(); j1 = rand_job();
        drive_req(0, j0, 1'b1);
        drive_req(1, j1, 1'b1);
        exp_id = 1'b0; ngr = 0; n = 0;
        #1;
        while (ngr < 4 && n < 200) begin
            checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                errors++; $display("FAIL double_ready got=11 want=one-hot");
            end
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                checks++;
                if (req1_ready !== exp_id) begin
                    errors++; $display("FAIL rr_order got=%b want=%b", req1_ready, exp_id);
                end
                exp_id = ~exp_id; ngr++;
            end
            @(negedge clk); #1; n++;
        end
        checks++;
        if (ngr != 4) begin errors++; $display("FAIL rr_grants got=%0d want=4", ngr); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int dis[6] = '{2, 0, 16, 17, 5, 5};
        int des[6] = '{0, 3, 4, 1, 16, 17};
        job_t j;
        bit got, mto; int lat, mlat, mi, me, i0, e0;
        logic rid, rto; logic [2*W-1:0] rmsg, mmsg;
        for (int t = 0; t < 6; t++) begin
            j = rand_job();
            inv_delay = dis[t]; exp_delay = des[t];
            i0 = inv_pulses; e0 = exp_pulses;
            do_job(t % 2, j, got, lat, rid, rto, rmsg);
            model(j, dis[t], des[t], mto, mmsg, mlat, mi, me);
            checks++;
            if (!got || lat != mlat || rto !== mto || rmsg !== mmsg || rid !== 1'(t % 2)) begin
                errors++;
                $display("FAIL timeout_%0d got=%b lat=%0d to=%b id=%b want lat=%0d to=%b id=%0d",
                         t, got, lat, rto, rid, mlat, mto, t % 2);
            end
            checks++;
            if (inv_pulses - i0 != mi || exp_pulses - e0 != me) begin
                errors++;
                $display("FAIL timeout_pulses_%0d got=%0d/%0d want=%0d/%0d", t,
                         inv_pulses - i0, exp_pulses - e0, mi, me);
            end
        end
    endtask

    task automatic test_backpressure();
        job_t j0, j1;
        int n, g;
        bit mto; int mlat, mi, me;
        logic [2*W-1:0] mmsg;
        inv_delay = 2; exp_delay = 2;
        j0 = rand_job(); j1 = rand_job();
        model(j0, 2, 2, mto, mmsg, mlat, mi, me);
        @(negedge clk);
        drive_req(0, j0, 1'b1);
        #1;
        n = 0;
        while (req0_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_req(0, j0, 1'b0);
        #1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        drive_req(1, j1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_timeout !== mto || rsp_msg !== mmsg
                || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d valid=%b id=%b to=%b rdy1=%b want 1 0 %b 0", i,
                         rsp_valid, rsp_id, rsp_timeout, req1_ready, mto);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_cycle valid=%b rdy1=%b want 1 0", rsp_valid, req1_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake valid=%b rdy1=%b want 0 1", rsp_valid, req1_ready);
        end
        g = cyc;
        @(negedge clk);
        drive_req(1, j1, 1'b0);
        model(j1, 2, 2, mto, mmsg, mlat, mi, me);
        #1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (rsp_valid !== 1'b1 || cyc - g != mlat || rsp_id !== 1'b1 || rsp_msg !== mmsg) begin
            errors++;
            $display("FAIL req1_after_hold valid=%b lat=%0d id=%b want 1 %0d 1", rsp_valid,
                     cyc - g, rsp_id, mlat);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        job_t j;
        int n;
        bit got, mto; int lat, mlat, mi, me;
        logic rid, rto; logic [2*W-1:0] rmsg, mmsg;
        inv_delay = 0; exp_delay = 3;
        j = rand_job();
        @(negedge clk);
        drive_req(0, j, 1'b1);
        #1;
        n = 0;
        while (req0_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_req(0, j, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ((|all_out) !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h want=0", all_out);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abandoned_job_%0d valid=%b busy=%b want 0 0", i, rsp_valid, busy);
            end
        end
        inv_delay = 2; exp_delay = 4;
        j = rand_job();
        do_job(1, j, got, lat, rid, rto, rmsg);
        model(j, 2, 4, mto, mmsg, mlat, mi, me);
        checks++;
        if (!got || lat != mlat || rid !== 1'b1 || rto !== mto || rmsg !== mmsg) begin
            errors++;
            $display("FAIL fresh_job got=%b lat=%0d id=%b to=%b want 1 %0d 1 %b", got, lat, rid,
                     rto, mlat, mto);
        end
    endtask

    task automatic test_random();
        job_t j;
        int k, di, de;
        bit got, mto; int lat, mlat, mi, me, i0, e0;
        logic rid, rto; logic [2*W-1:0] rmsg, mmsg;
        for (int t = 0; t < 16; t++) begin
            j = rand_job();
            k = $urandom_range(0, 1);
            di = $urandom_range(0, 18);
            de = $urandom_range(0, 18);
            inv_delay = di; exp_delay = de;
            i0 = inv_pulses; e0 = exp_pulses;
            do_job(k, j, got, lat, rid, rto, rmsg);
            model(j, di, de, mto, mmsg, mlat, mi, me);
            checks++;
            if (!got || lat != mlat || rid !== 1'(k) || rto !== mto || rmsg !== mmsg) begin
                errors++;
                $display("FAIL random_%0d got=%b lat=%0d id=%b to=%b want 1 %0d %0d %b (di=%0d de=%0d)",
                         t, got, lat, rid, rto, mlat, k, mto, di, de);
            end
            checks++;
            if (inv_pulses - i0 != mi || exp_pulses - e0 != me) begin
                errors++;
                $display("FAIL random_pulses_%0d got=%0d/%0d want=%0d/%0d", t,
                         inv_pulses - i0, exp_pulses - e0, mi, me);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_job_scheduler.md
RSA_JOB_SCHEDULER -- requirements
Module: rsa_job_scheduler

Interface
REQ-001 The module SHALL have parameter WIDTH, default 128, giving the bit width of p and q; messages are 2*WIDTH bits.
REQ-002 The module SHALL have parameter TIMEOUT, default 65535, giving the maximum cycles spent in either wait phase.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 reqK_valid  in  1  requester K (K=0,1) presents a job.
REQ-006 reqK_ready  out  1  job from requester K accepted this cycle.
REQ-007 reqK_p, reqK_q  in  WIDTH each  job primes.
REQ-008 reqK_encrypt_decrypt  in  1  job mode (0 = encrypt, 1 = decrypt).
REQ-009 reqK_msg  in  2*WIDTH  job message.
REQ-010 eng_p, eng_q, eng_encrypt_decrypt, eng_msg  out  WIDTH, WIDTH, 1, 2*WIDTH  operands to the control engine.
REQ-011 eng_reset_inverter, eng_reset_mod_exp  out  1 each  engine phase-start pulses.
REQ-012 eng_inverter_finish, eng_mod_exp_finish  in  1 each  engine phase-done levels.
REQ-013 eng_msg_out  in  2*WIDTH  engine result.
REQ-014 rsp_valid  out  1  result available.
REQ-015 rsp_ready  in  1  consumer accepts the result.
REQ-016 rsp_id  out  1  index of the requester that owns the result.
REQ-017 rsp_msg  out  2*WIDTH  result message.
REQ-018 rsp_timeout  out  1  the job aborted on timeout.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL use states IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT and DONE.
REQ-021 In IDLE with any reqK_valid high, the FSM SHALL grant exactly one requester, assert its reqK_ready for that cycle only, latch its operands and id, and go to INV_RST.
REQ-022 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; after reset, req0 has priority.
REQ-023 reqK_ready SHALL never be high outside IDLE, and SHALL never be high for both requesters in the same cycle.
REQ-024 eng_* operands SHALL hold the latched job values, stable from INV_RST through DONE.
REQ-025 INV_RST SHALL assert eng_reset_inverter for exactly one cycle and then go to INV_WAIT.
REQ-026 INV_WAIT SHALL go to EXP_RST on the first cycle eng_inverter_finish is sampled high.
REQ-027 EXP_RST SHALL assert eng_reset_mod_exp for exactly one cycle and then go to EXP_WAIT.
REQ-028 EXP_WAIT SHALL go to DONE on the first cycle eng_mod_exp_finish is high, capturing eng_msg_out into rsp_msg with rsp_timeout=0.
REQ-029 A wait-cycle counter SHALL clear on entry to each wait state; when it reaches TIMEOUT, the FSM SHALL go to DONE with rsp_msg=0 and rsp_timeout=1.
REQ-030 A finish input that rises on the same cycle the counter reaches TIMEOUT SHALL win, giving a normal completion.
REQ-031 DONE SHALL hold rsp_valid high with rsp_id, rsp_msg and rsp_timeout stable until rsp_ready is high; it then returns to IDLE the next cycle. No new grant is made in that handshake cycle.
REQ-032 The minimum latency from grant to rsp_valid SHALL be 5 cycles, reached when each finish input is high on the first wait cycle.

Reset
REQ-033 While reset_n is low at a clock edge, the block SHALL enter IDLE, clear the counter, and set the round-robin pointer to favour req0.
REQ-034 While reset_n is low, all outputs SHALL be 0: ready, eng_* operands and pulses, rsp_*, busy.
REQ-035 Reset mid-job SHALL abandon the job without producing a response.

Structure
REQ-036 The FSM state encoding and the default TIMEOUT SHALL reside in shared package rsa_sched_pkg.
REQ-037 The round-robin arbiter SHALL be the single sub-module rsa_rr_arb2, containing the two valids, a grant-enable input, a one-hot grant output and the last-grant register.

Verification
REQ-038 Single job: req0 with p=113680897410347, q=7999808077935876437321, ed=0, msg=0x806a3e00000000000000000000, against an engine model finishing 3 cycles after each pulse -> exactly one pulse per phase; rsp_valid with rsp_id=0, rsp_timeout=0 and rsp_msg equal to the model output, 9 cycles after grant.
REQ-039 Both requesters valid in the same cycle, repeated -> grants alternate 0,1,0,1, with no double ready.
REQ-040 Engine never raises eng_mod_exp_finish, TIMEOUT=16 -> DONE 16 cycles after entering EXP_WAIT, with rsp_timeout=1 and rsp_msg=0.
REQ-041 rsp_ready held low 10 cycles -> rsp_valid and data stable for those cycles; req1 valid during that time is not granted until the cycle after the response handshake.
REQ-042 reset_n driven low during INV_WAIT -> the next cycle has all outputs 0 and no response; a fresh req1 job then completes normally.
